// File: rtl/axi_bridge_pkg.sv
// rtl/axi_bridge_pkg.sv - Shared FSM states and AXI constants for the cache bridge
package axi_bridge_pkg;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [7:0] LINE_LEN   = 8'd3;
  localparam logic [2:0] SIZE_WORD  = 3'd2;

  // Line bursts are LINE_LEN+1 beats, everything else is a single beat.
  function automatic logic [7:0] burst_len(input logic line);
    return line ? LINE_LEN : 8'd0;
  endfunction

  // Line bursts always move whole words; singles keep the requester's size.
  function automatic logic [2:0] burst_size(input logic line, input logic [2:0] size);
    return line ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/axi_wr_beat_gen.sv
// rtl/axi_wr_beat_gen.sv - W-channel beat counter and last-beat detection
module axi_wr_beat_gen
  import axi_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_active,
  input  logic       i_line,
  input  logic       i_wready,
  output logic [1:0] o_beat,
  output logic       o_last,
  output logic       o_final
);

  logic [1:0] r_beat;

  // Count accepted beats while the W channel is open; park at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= 2'd0;
    end else if (!i_active) begin
      r_beat <= 2'd0;
    end else if (i_wready && !o_last) begin
      r_beat <= r_beat + 2'd1;
    end
  end

  assign o_beat  = r_beat;
  assign o_last  = i_line ? (r_beat == LINE_LEN[1:0]) : 1'b1;
  assign o_final = i_active && i_wready && o_last;

endmodule

// File: rtl/axi_bridge.sv
// rtl/axi_bridge.sv - Cache-to-AXI bridge with concurrent read and write engines
module axi_bridge
  import axi_bridge_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    inst_rd_req,
  input  logic                    inst_rd_type,
  input  logic [31:0]             inst_rd_addr,
  output logic                    inst_rd_gnt,
  output logic                    inst_ret_valid,
  output logic                    inst_ret_last,
  output logic [31:0]             inst_ret_data,
  input  logic                    data_rd_req,
  input  logic                    data_rd_type,
  input  logic [2:0]              data_rd_size,
  input  logic [31:0]             data_rd_addr,
  output logic                    data_rd_gnt,
  output logic                    data_ret_valid,
  output logic                    data_ret_last,
  output logic [31:0]             data_ret_data,
  input  logic                    data_wr_req,
  input  logic                    data_wr_type,
  input  logic [2:0]              data_wr_size,
  input  logic [31:0]             data_wr_addr,
  input  logic [3:0]              data_wr_strb,
  input  logic [32*LINE_WORDS-1:0] data_wr_data,
  output logic                    data_wr_gnt,
  output logic                    data_wr_done,
  output logic [3:0]              arid,
  output logic [31:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [3:0]              rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [3:0]              awid,
  output logic [31:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [3:0]              wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [3:0]              bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  r_state_e r_rstate, w_rnext;
  w_state_e r_wstate, w_wnext;

  logic [31:0] r_raddr;
  logic [3:0]  r_rid;
  logic        r_rline;
  logic [2:0]  r_rsize;
  logic        r_inst_gnt;
  logic        r_data_gnt;

  logic [31:0]             r_waddr;
  logic [2:0]              r_wsize;
  logic                    r_wline;
  logic [3:0]              r_wstrb;
  logic [32*LINE_WORDS-1:0] r_wdata;
  logic                    r_wr_gnt;
  logic                    r_wr_done;

  logic       w_hazard;
  logic       w_data_take;
  logic       w_inst_take;
  logic       w_beat_ok;
  logic [1:0] w_beat;
  logic       w_last;
  logic       w_final;
  logic       w_unused;

  // Response codes and write IDs carry nothing the caches can act on.
  assign w_unused = ^{rresp, bresp, bid};

  // A data read to the line still being written must wait for that write to retire.
  assign w_hazard    = (r_wstate != W_IDLE) && (data_rd_addr[31:4] == r_waddr[31:4]);
  assign w_data_take = data_rd_req && !w_hazard;
  assign w_inst_take = inst_rd_req && !w_data_take;
  assign w_beat_ok   = (r_rstate == R_DATA) && rvalid && (rid == r_rid);

  // Read FSM next-state: one outstanding burst at a time.
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_data_take || w_inst_take) w_rnext = R_AR;
      R_AR:    if (arready) w_rnext = R_DATA;
      R_DATA:  if (w_beat_ok && rlast) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rstate <= R_IDLE;
    else          r_rstate <= w_rnext;
  end

  // Capture the winning read request and pulse its grant the following cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_raddr    <= 32'd0;
      r_rid      <= 4'd0;
      r_rline    <= 1'b0;
      r_rsize    <= 3'd0;
      r_inst_gnt <= 1'b0;
      r_data_gnt <= 1'b0;
    end else begin
      r_inst_gnt <= 1'b0;
      r_data_gnt <= 1'b0;
      if (r_rstate == R_IDLE) begin
        if (w_data_take) begin
          r_raddr    <= data_rd_addr;
          r_rid      <= ID_DATA;
          r_rline    <= data_rd_type;
          r_rsize    <= data_rd_size;
          r_data_gnt <= 1'b1;
        end else if (w_inst_take) begin
          r_raddr    <= inst_rd_addr;
          r_rid      <= ID_INST;
          r_rline    <= inst_rd_type;
          r_rsize    <= SIZE_WORD;
          r_inst_gnt <= 1'b1;
        end
      end
    end
  end

  assign inst_rd_gnt = r_inst_gnt;
  assign data_rd_gnt = r_data_gnt;

  assign arvalid = (r_rstate == R_AR);
  assign arid    = r_rid;
  assign araddr  = r_raddr;
  assign arlen   = burst_len(r_rline);
  assign arsize  = burst_size(r_rline, r_rsize);
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (r_rstate == R_DATA);

  assign inst_ret_valid = w_beat_ok && !rid[0];
  assign inst_ret_last  = inst_ret_valid && rlast;
  assign inst_ret_data  = inst_ret_valid ? rdata : 32'd0;
  assign data_ret_valid = w_beat_ok && rid[0];
  assign data_ret_last  = data_ret_valid && rlast;
  assign data_ret_data  = data_ret_valid ? rdata : 32'd0;

  // Write FSM next-state: address, data beats, then wait for the B response.
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  if (data_wr_req) w_wnext = W_AW;
      W_AW:    if (awready) w_wnext = W_DATA;
      W_DATA:  if (w_final) w_wnext = W_RESP;
      W_RESP:  if (bvalid) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wnext;
  end

  // Capture the write request; grant and done are one-cycle registered pulses.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_waddr   <= 32'd0;
      r_wsize   <= 3'd0;
      r_wline   <= 1'b0;
      r_wstrb   <= 4'd0;
      r_wdata   <= '0;
      r_wr_gnt  <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_wr_gnt  <= 1'b0;
      r_wr_done <= (r_wstate == W_RESP) && bvalid;
      if (r_wstate == W_IDLE && data_wr_req) begin
        r_waddr  <= data_wr_addr;
        r_wsize  <= data_wr_size;
        r_wline  <= data_wr_type;
        r_wstrb  <= data_wr_strb;
        r_wdata  <= data_wr_data;
        r_wr_gnt <= 1'b1;
      end
    end
  end

  axi_wr_beat_gen u_beat_gen (
    .clk      (aclk),
    .rst_n    (aresetn),
    .i_active (r_wstate == W_DATA),
    .i_line   (r_wline),
    .i_wready (wready),
    .o_beat   (w_beat),
    .o_last   (w_last),
    .o_final  (w_final)
  );

  assign data_wr_gnt  = r_wr_gnt;
  assign data_wr_done = r_wr_done;

  assign awvalid = (r_wstate == W_AW);
  assign awid    = ID_DATA;
  assign awaddr  = r_waddr;
  assign awlen   = burst_len(r_wline);
  assign awsize  = burst_size(r_wline, r_wsize);
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wvalid = (r_wstate == W_DATA);
  assign wid    = ID_DATA;
  assign wdata  = r_wdata[{w_beat, 5'd0} +: 32];
  assign wstrb  = r_wline ? 4'hF : r_wstrb;
  assign wlast  = wvalid && w_last;
  assign bready = (r_wstate == W_RESP);

endmodule

// File: tb/tb_axi_bridge.sv
// tb/tb_axi_bridge.sv - Directed and randomized checks of axi_bridge against an AXI slave model
module tb_axi_bridge;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic         inst_rd_req, inst_rd_type;
  logic [31:0]  inst_rd_addr;
  logic         inst_rd_gnt, inst_ret_valid, inst_ret_last;
  logic [31:0]  inst_ret_data;
  logic         data_rd_req, data_rd_type;
  logic [2:0]   data_rd_size;
  logic [31:0]  data_rd_addr;
  logic         data_rd_gnt, data_ret_valid, data_ret_last;
  logic [31:0]  data_ret_data;
  logic         data_wr_req, data_wr_type;
  logic [2:0]   data_wr_size;
  logic [31:0]  data_wr_addr;
  logic [3:0]   data_wr_strb;
  logic [127:0] data_wr_data;
  logic         data_wr_gnt, data_wr_done;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst, awlock;
  logic [3:0]   awcache;
  logic [2:0]   awprot;
  logic         awvalid, awready;
  logic [3:0]   wid;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axi_bridge #(.LINE_WORDS(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_gnt(inst_rd_gnt), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_ret_data(inst_ret_data),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_size(data_rd_size),
    .data_rd_addr(data_rd_addr), .data_rd_gnt(data_rd_gnt), .data_ret_valid(data_ret_valid),
    .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_size(data_wr_size),
    .data_wr_addr(data_wr_addr), .data_wr_strb(data_wr_strb), .data_wr_data(data_wr_data),
    .data_wr_gnt(data_wr_gnt), .data_wr_done(data_wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge aclk);
    #1;
  endtask

  // Slave side of one read burst: AR handshake, one foreign-ID beat, then nb owned beats.
  task automatic serve_read(input logic [3:0] id, input logic [31:0] addr, input int nb,
                            input logic [2:0] sz, input int ar_delay, input bit rnd);
    int t;
    logic [31:0] w;
    t = 0;
    while (arvalid !== 1'b1 && t < 20) begin cyc(); t++; end
    chk("ar_valid", arvalid, 1);
    chk("ar_addr", araddr, addr);
    chk("ar_id", arid, id);
    chk("ar_len", arlen, nb - 1);
    chk("ar_size", arsize, sz);
    chk("ar_burst", arburst, 1);
    chk("ar_misc", {arlock, arcache, arprot}, 0);
    for (int i = 0; i < ar_delay; i++) begin
      cyc();
      chk("ar_hold_v", arvalid, 1);
      chk("ar_hold_a", araddr, addr);
    end
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("ar_drop", arvalid, 0);
    chk("r_ready", rready, 1);
    chk("gnt_pulse", {inst_rd_gnt, data_rd_gnt}, 0);
    rvalid = 1'b1; rid = id ^ 4'h5; rdata = $urandom; rlast = 1'b1;
    #1;
    chk("stray_i", inst_ret_valid, 0);
    chk("stray_d", data_ret_valid, 0);
    cyc();
    chk("stray_keep", rready, 1);
    for (int k = 0; k < nb; k++) begin
      w = rnd ? $urandom : 32'hA0 + k;
      rvalid = 1'b1; rid = id; rdata = w; rresp = 2'($urandom); rlast = (k == nb - 1);
      #1;
      chk("ret_v_own", id[0] ? data_ret_valid : inst_ret_valid, 1);
      chk("ret_v_other", id[0] ? inst_ret_valid : data_ret_valid, 0);
      chk("ret_data", id[0] ? data_ret_data : inst_ret_data, w);
      chk("ret_last", id[0] ? data_ret_last : inst_ret_last, k == nb - 1);
      cyc();
      if (k < nb - 1 && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("gap_v", id[0] ? data_ret_valid : inst_ret_valid, 0);
        chk("gap_rdy", rready, 1);
        cyc();
      end
    end
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("r_done", rready, 0);
  endtask

  task automatic do_read(input bit is_data, input bit line, input logic [2:0] size,
                         input logic [31:0] addr, input int ar_delay, input bit rnd);
    cyc();
    if (is_data) begin
      data_rd_req = 1'b1; data_rd_type = line; data_rd_size = size; data_rd_addr = addr;
    end else begin
      inst_rd_req = 1'b1; inst_rd_type = line; inst_rd_addr = addr;
    end
    cyc();
    chk("rd_gnt_own", is_data ? data_rd_gnt : inst_rd_gnt, 1);
    chk("rd_gnt_other", is_data ? inst_rd_gnt : data_rd_gnt, 0);
    data_rd_req = 1'b0;
    inst_rd_req = 1'b0;
    serve_read(is_data ? 4'd1 : 4'd0, addr, line ? 4 : 1,
               line ? 3'd2 : (is_data ? size : 3'd2), ar_delay, rnd);
  endtask

  task automatic start_write(input bit line, input logic [2:0] sz, input logic [31:0] a,
                             input logic [3:0] st, input logic [127:0] d);
    cyc();
    data_wr_req = 1'b1; data_wr_type = line; data_wr_size = sz;
    data_wr_addr = a; data_wr_strb = st; data_wr_data = d;
    cyc();
    chk("wr_gnt", data_wr_gnt, 1);
    chk("aw_valid", awvalid, 1);
    data_wr_req = 1'b0;
    cyc();
    chk("wr_gnt_pulse", data_wr_gnt, 0);
  endtask

  // Slave side of a write already in the address phase; hz also watches a held hazard read.
  task automatic finish_write(input bit line, input logic [2:0] sz, input logic [31:0] a,
                              input logic [3:0] st, input logic [127:0] d,
                              input int aw_delay, input bit toggle, input bit hz);
    int k, t, nb;
    nb = line ? 4 : 1;
    chk("aw_valid2", awvalid, 1);
    chk("aw_addr", awaddr, a);
    chk("aw_id", awid, 1);
    chk("aw_len", awlen, nb - 1);
    chk("aw_size", awsize, line ? 3'd2 : sz);
    chk("aw_burst", awburst, 1);
    chk("aw_misc", {awlock, awcache, awprot}, 0);
    for (int i = 0; i < aw_delay; i++) begin cyc(); chk("aw_hold", awvalid, 1); end
    awready = 1'b1;
    cyc();
    awready = 1'b0;
    chk("aw_drop", awvalid, 0);
    k = 0; t = 0;
    while (k < nb && t < 40) begin
      wready = toggle ? t[0] : 1'($urandom_range(0, 1));
      #1;
      chk("w_valid", wvalid, 1);
      chk("w_id", wid, 1);
      chk("w_data", wdata, d[32*k +: 32]);
      chk("w_strb", wstrb, line ? 4'hF : st);
      chk("w_last", wlast, k == nb - 1);
      if (hz) chk("hz_wait", data_rd_gnt, 0);
      if (wready) k++;
      cyc();
      t++;
    end
    wready = 1'b0;
    chk("w_beats", k, nb);
    chk("w_end", wvalid, 0);
    chk("b_ready", bready, 1);
    repeat ($urandom_range(0, 2)) begin cyc(); chk("b_wait", data_wr_done, 0); end
    bvalid = 1'b1; bid = 4'd1; bresp = 2'($urandom);
    #1;
    chk("done_early", data_wr_done, 0);
    cyc();
    bvalid = 1'b0;
    chk("done", data_wr_done, 1);
    chk("b_drop", bready, 0);
    if (hz) chk("hz_at_done", data_rd_gnt, 0);
    cyc();
    chk("done_pulse", data_wr_done, 0);
    if (hz) chk("hz_release", data_rd_gnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    logic [31:0]  a;
    logic [3:0]   st;
    logic [2:0]   sz;
    bit           dsel, ln;
    int           t;

    aresetn = 1'b0;
    inst_rd_req = 0; inst_rd_type = 0; inst_rd_addr = 0;
    data_rd_req = 0; data_rd_type = 0; data_rd_size = 0; data_rd_addr = 0;
    data_wr_req = 0; data_wr_type = 0; data_wr_size = 0; data_wr_addr = 0;
    data_wr_strb = 0; data_wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) cyc();
    chk("rst_vr", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_pulses", {inst_rd_gnt, data_rd_gnt, data_wr_gnt, data_wr_done,
                       inst_ret_valid, data_ret_valid}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    aresetn = 1'b1;

    // icache line fill with arready after two cycles, beats 0xA0..0xA3
    do_read(1'b0, 1'b1, 3'd2, 32'h1C00_0000, 2, 1'b0);

    // simultaneous inst and data requests: data first, inst after data rlast
    cyc();
    inst_rd_req = 1; inst_rd_type = 1; inst_rd_addr = 32'h1C00_0040;
    data_rd_req = 1; data_rd_type = 1; data_rd_size = 3'd2; data_rd_addr = 32'h0000_1000;
    cyc();
    chk("pri_dgnt", data_rd_gnt, 1);
    chk("pri_ignt", inst_rd_gnt, 0);
    chk("pri_arid", arid, 1);
    data_rd_req = 0;
    serve_read(4'd1, 32'h0000_1000, 4, 3'd2, 1, 1'b1);
    t = 0;
    while (inst_rd_gnt !== 1'b1 && t < 10) begin cyc(); t++; end
    chk("pri_ignt_after", inst_rd_gnt, 1);
    inst_rd_req = 0;
    serve_read(4'd0, 32'h1C00_0040, 4, 3'd2, 0, 1'b1);

    // data line write with wready toggling
    d = {$urandom, $urandom, $urandom, $urandom};
    start_write(1'b1, 3'd2, 32'h8000_0040, 4'hF, d);
    finish_write(1'b1, 3'd2, 32'h8000_0040, 4'hF, d, 1, 1'b1, 1'b0);

    // read-after-write hazard on the same line; other lines pass
    d = {$urandom, $urandom, $urandom, $urandom};
    start_write(1'b1, 3'd2, 32'h8000_0040, 4'hF, d);
    data_rd_req = 1; data_rd_type = 0; data_rd_size = 3'd2; data_rd_addr = 32'h8000_0048;
    repeat (3) begin cyc(); chk("hz_block", data_rd_gnt, 0); end
    data_rd_req = 0;
    do_read(1'b1, 1'b0, 3'd2, 32'h8000_0100, 0, 1'b1);
    data_rd_req = 1; data_rd_type = 0; data_rd_size = 3'd2; data_rd_addr = 32'h8000_0048;
    finish_write(1'b1, 3'd2, 32'h8000_0040, 4'hF, d, 0, 1'b1, 1'b1);
    data_rd_req = 0;
    serve_read(4'd1, 32'h8000_0048, 1, 3'd2, 0, 1'b1);

    // single uncached byte read
    do_read(1'b1, 1'b0, 3'd0, 32'hBFAF_8003, 0, 1'b1);

    // reset during the second beat of a line read
    cyc();
    inst_rd_req = 1; inst_rd_type = 1; inst_rd_addr = 32'h1C00_0080;
    cyc();
    chk("rst_gnt", inst_rd_gnt, 1);
    inst_rd_req = 0;
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rid = 4'd0; rdata = 32'h11; rlast = 0;
    #1;
    chk("rst_b1", inst_ret_valid, 1);
    cyc();
    rdata = 32'h22;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_ar", arvalid, 0);
    chk("rst_mid_r", rready, 0);
    chk("rst_mid_ret", inst_ret_valid, 0);
    chk("rst_mid_gnt", {inst_rd_gnt, data_rd_gnt, data_wr_gnt, data_wr_done}, 0);
    cyc();
    rvalid = 0;
    chk("rst_hold", {arvalid, rready, inst_ret_valid, data_ret_valid}, 0);
    aresetn = 1'b1;
    cyc();
    chk("rst_after", {arvalid, rready, inst_rd_gnt}, 0);
    do_read(1'b0, 1'b1, 3'd2, 32'h1C00_0100, 1, 1'b1);

    // randomized reads
    for (int i = 0; i < 6; i++) begin
      dsel = 1'($urandom_range(0, 1));
      ln   = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 2));
      a    = $urandom;
      do_read(dsel, ln, sz, a, $urandom_range(0, 3), 1'b1);
    end

    // randomized writes
    for (int i = 0; i < 4; i++) begin
      ln = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a  = $urandom;
      st = 4'($urandom);
      d  = {$urandom, $urandom, $urandom, $urandom};
      start_write(ln, sz, a, st, d);
      finish_write(ln, sz, a, st, d, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_bridge.md
AXI_BRIDGE -- requirements
Module: axi_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per cache-line burst (fixed 4 in this revision).
REQ-002 SHALL have port aclk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port inst_rd_req / inst_rd_type / inst_rd_addr  input  1/1/32  icache read request; type 0=single word, 1=line.
REQ-005 SHALL have port inst_rd_gnt / inst_ret_valid / inst_ret_last / inst_ret_data  output  1/1/1/32  grant pulse and returned beats.
REQ-006 SHALL have port data_rd_req / data_rd_type / data_rd_size / data_rd_addr  input  1/1/3/32  dcache or uncached read request.
REQ-007 SHALL have port data_rd_gnt / data_ret_valid / data_ret_last / data_ret_data  output  1/1/1/32  grant pulse and returned beats.
REQ-008 SHALL have port data_wr_req / data_wr_type / data_wr_size / data_wr_addr / data_wr_strb / data_wr_data  input  1/1/3/32/4/128  write request; single-word writes use data bits [31:0].
REQ-009 SHALL have port data_wr_gnt / data_wr_done  output  1/1  grant pulse; done pulse on B response.
REQ-010 SHALL have AR channel arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  output  4/32/8/3/2/2/4/3/1; arready  input  1.
REQ-011 SHALL have R channel rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1; rready  output  1.
REQ-012 SHALL have AW channel awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  output  4/32/8/3/2/2/4/3/1; awready  input  1.
REQ-013 SHALL have W channel wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1; wready  input  1; B channel bid/bresp/bvalid  input  4/2/1; bready  output  1.

Function
REQ-014 Read FSM SHALL use states R_IDLE, R_AR, R_DATA; write FSM SHALL use W_IDLE, W_AW, W_DATA, W_RESP; both run concurrently.
REQ-015 In R_IDLE with any read request, SHALL latch one request, pulse its *_rd_gnt for exactly one cycle, go to R_AR; data read has priority over inst read.
REQ-016 In R_AR SHALL hold arvalid=1 with stable payload until arready, then go to R_DATA.
REQ-017 AR payload SHALL be arid=0 (inst) / 1 (data); arlen=3 for line, 0 for single; arsize=2 for line, latched size for single; arburst=2'b01; arlock/arcache/arprot=0.
REQ-018 In R_DATA rready SHALL be 1; each rvalid beat SHALL drive the owner's *_ret_valid=1, *_ret_data=rdata, *_ret_last=rlast combinationally, selected by rid[0].
REQ-019 R_DATA SHALL return to R_IDLE on rvalid&&rlast; a new request is accepted no earlier than the following cycle.
REQ-020 In W_IDLE with data_wr_req SHALL latch addr/size/type/strb/128-bit data, pulse data_wr_gnt one cycle, go to W_AW.
REQ-021 W_AW SHALL hold awvalid with awid=1, awlen=3/0, awsize as AR rule, awburst=2'b01, others 0, until awready, then go to W_DATA.
REQ-022 W_DATA SHALL drive wvalid=1, wid=1, wdata=beat word (beat counter 0..3, word k = data[32k+31:32k]), wstrb=4'hF for line else latched strb, wlast on final beat; counter advances only on wready.
REQ-023 After final beat accepted SHALL enter W_RESP with bready=1; on bvalid SHALL pulse data_wr_done one cycle and return to W_IDLE.
REQ-024 Read-after-write hazard: while write FSM not in W_IDLE, a data read with addr[31:4] equal to latched write addr[31:4] SHALL NOT be granted until the cycle after data_wr_done; inst reads are unaffected.
REQ-025 rresp and bresp SHALL be ignored; beats with rid not matching the outstanding read SHALL not be forwarded.

Reset
REQ-026 On aresetn=0 both FSMs SHALL enter idle states immediately; all valid/ready/gnt/done/ret outputs SHALL be 0; payload registers SHALL clear to 0.
REQ-027 Reset mid-burst SHALL abandon the transaction with no further beats, grants, or done pulses.

Structure
REQ-028 A shared package SHALL hold FSM state enums, AXI constants (BURST_INCR=2'b01, ID_INST=0, ID_DATA=1, LINE_LEN=3, SIZE_WORD=2).
REQ-029 Single optional sub-module axi_wr_beat_gen SHALL hold W-channel beat counter and wlast logic; read path stays inline.

Verification
REQ-030 inst line read at 0x1C00_0000, slave arready after 2 cycles, 4 beats 0xA0..0xA3 -> arid=0, arlen=3, four inst_ret_valid, ret_last only on 0xA3.
REQ-031 inst and data read requests same cycle -> data_rd_gnt first, arid=1; inst granted after data rlast.
REQ-032 data line write to 0x8000_0040 with wready toggling every other cycle -> 4 beats in order, wlast on 4th, data_wr_done one cycle after bvalid.
REQ-033 data write 0x8000_0040 pending, data read 0x8000_0048 requested -> no data_rd_gnt until cycle after data_wr_done; read 0x8000_0100 granted immediately.
REQ-034 single uncached read size=0 at 0xBFAF_8003 -> arlen=0, arsize=0, one beat with ret_last=1.
REQ-035 aresetn low during beat 2 of line read -> arvalid/rready/ret_valid 0 immediately; post-reset new request proceeds normally.
